// File: rtl/sdram_pattern_checker.sv
// Read-back verifier: regenerates the LFSR training/input image and compares it word by word
// with SDRAM read data, one outstanding read at a time, reporting error count and first mismatch.
//
// state | meaning
// IDLE  | waiting for start; results of the last pass held
// GEN   | advance LFSR for the next element
// ISSUE | one-cycle read strobe
// WAIT  | sample readdata RD_LAT cycles after the strobe, pad out to GAP
// CHECK | compare, count errors, advance word/element/address
// DONE  | one-cycle done pulse, latch pass
module sdram_pattern_checker #(
    parameter int M       = 6,
    parameter int N       = 10,
    parameter int W       = 16,
    parameter int L       = 6,
    parameter int N_INPUT = 10,
    parameter int ADDR_W  = 25,
    parameter logic [ADDR_W-1:0] BASE_T_ADDR = '0,
    parameter logic [ADDR_W-1:0] BASE_I_ADDR = ADDR_W'(1) << (ADDR_W - 1),
    parameter int RD_LAT  = 2,
    parameter int GAP     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      readdata,
    output logic              read,
    output logic [ADDR_W-1:0] readaddress,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [W-1:0]      first_err_exp,
    output logic [W-1:0]      first_err_got
);

    localparam int WPE     = M * N + 1;
    localparam int N_TRAIN = 1 << L;
    localparam int N_ELEM  = N_TRAIN + N_INPUT;
    localparam int WW      = $clog2(WPE + 1);
    localparam int EW      = $clog2(N_ELEM + 1);
    localparam int CW      = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [6:0]      lfsr;
    logic [6:0]      lfsr_nxt;
    logic [6:0]      rv;
    logic [2:0]      elem_type;
    logic [WW-1:0]   word_idx;
    logic [EW-1:0]   elem_idx;
    logic [CW-1:0]   gap_cnt;
    logic [W-1:0]    rdata_q;
    logic [W-1:0]    exp_word;
    logic            last_word, last_elem, is_train;
    logic            sample, wait_exit, mismatch;

    assign lfsr_nxt  = {lfsr[5:0], ~(lfsr[6] ^ lfsr[4] ^ lfsr[3] ^ lfsr[2])};
    assign rv        = lfsr % 7'd100;
    assign last_word = (word_idx == WW'(WPE - 1));
    assign last_elem = (elem_idx == EW'(N_ELEM - 1));
    assign is_train  = (elem_idx < EW'(N_TRAIN));

    always_comb begin
        elem_type = 3'd0;
        if (is_train) begin
            if (rv < 7'd20)      elem_type = 3'd1;
            else if (rv < 7'd40) elem_type = 3'd2;
            else if (rv < 7'd60) elem_type = 3'd3;
            else if (rv < 7'd80) elem_type = 3'd4;
            else                 elem_type = 3'd5;
        end
    end

    assign exp_word = (word_idx == '0) ? W'(elem_type) : W'(rv);
    assign mismatch = (rdata_q != exp_word);

    // Leave WAIT early enough that the next strobe lands exactly GAP cycles later,
    // one cycle earlier when a GEN cycle sits in between; never before the sample.
    assign sample    = (state == S_WAIT) && (gap_cnt == CW'(GAP - RD_LAT));
    assign wait_exit = (gap_cnt <= (last_word ? CW'(3) : CW'(2))) &&
                       (gap_cnt <= CW'(GAP - RD_LAT));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_GEN;
            S_GEN:   state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (wait_exit) state_nxt = S_CHECK;
            S_CHECK: begin
                if (!last_word)     state_nxt = S_ISSUE;
                else if (last_elem) state_nxt = S_DONE;
                else                state_nxt = S_GEN;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read = (state == S_ISSUE);
        done = (state == S_DONE);
        busy = (state != S_IDLE) && (state != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst)                  gap_cnt <= '0;
        else if (state == S_ISSUE) gap_cnt <= CW'(GAP - 1);
        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr           <= 7'd1;
            word_idx       <= '0;
            elem_idx       <= '0;
            readaddress    <= BASE_T_ADDR;
            rdata_q        <= '0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lfsr           <= 7'd1;
                    word_idx       <= '0;
                    elem_idx       <= '0;
                    readaddress    <= BASE_T_ADDR;
                    pass           <= 1'b0;
                    error_count    <= '0;
                    first_err_addr <= '0;
                    first_err_exp  <= '0;
                    first_err_got  <= '0;
                end
                S_GEN:  lfsr <= lfsr_nxt;
                S_WAIT: if (sample) rdata_q <= readdata;
                S_CHECK: begin
                    if (mismatch) begin
                        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                        if (error_count == '0) begin
                            first_err_addr <= readaddress;
                            first_err_exp  <= exp_word;
                            first_err_got  <= rdata_q;
                        end
                    end
                    if (last_word) begin
                        word_idx <= '0;
                        elem_idx <= elem_idx + EW'(1);
                        if (elem_idx == EW'(N_TRAIN - 1)) readaddress <= BASE_I_ADDR;
                        else                              readaddress <= readaddress + ADDR_W'(W);
                    end else begin
                        word_idx    <= word_idx + WW'(1);
                        readaddress <= readaddress + ADDR_W'(W);
                    end
                end
                S_DONE: pass <= (error_count == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Bench for sdram_pattern_checker: SDRAM model driving random junk outside the sample slot,
// read-address/spacing scoreboard against an arithmetic model of the pattern image.
module tb_sdram_pattern_checker;

    localparam int RD_LAT = 2;
    localparam int GAP    = 8;
    localparam int WPE    = 61;
    localparam int NELEM  = 74;
    localparam int NREAD  = NELEM * WPE;
    localparam int BASE_I = 32'h1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] readdata;
    logic        read;
    logic [24:0] readaddress;
    logic        busy, done, pass;
    logic [15:0] error_count;
    logic [24:0] first_err_addr;
    logic [15:0] first_err_exp, first_err_got;

    sdram_pattern_checker dut (
        .clk(clk), .rst(rst), .start(start), .readdata(readdata),
        .read(read), .readaddress(readaddress), .busy(busy), .done(done),
        .pass(pass), .error_count(error_count), .first_err_addr(first_err_addr),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          exp_addr [NREAD];
    int          exp_data [NREAD];
    logic [15:0] mem [int];

    function automatic void build_model();
        int lfsr, fb, rv, ty, base, idx;
        lfsr = 1;
        idx  = 0;
        for (int e = 0; e < NELEM; e++) begin
            fb   = 1 ^ (((lfsr >> 6) ^ (lfsr >> 4) ^ (lfsr >> 3) ^ (lfsr >> 2)) & 1);
            lfsr = ((lfsr << 1) | fb) & 127;
            rv   = lfsr % 100;
            ty   = (e < 64) ? rv / 20 + 1 : 0;
            base = (e < 64) ? e * WPE * 16 : BASE_I + (e - 64) * WPE * 16;
            for (int w = 0; w < WPE; w++) begin
                exp_addr[idx] = base + w * 16;
                exp_data[idx] = (w == 0) ? ty : rv;
                idx++;
            end
        end
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pend_t[$];
    int pend_a[$];
    int rd_idx   = 0;
    int last_rd  = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && read) begin
            if (rd_idx < NREAD) check_val("rd_addr", 32'(readaddress), exp_addr[rd_idx]);
            else                check_val("rd_overrun", rd_idx, NREAD - 1);
            if (rd_idx > 0) check_val("rd_gap", cyc - last_rd, GAP);
            if (rd_idx == 64 * WPE) check_val("elem64_addr", 32'(readaddress), BASE_I);
            if (rd_idx == NREAD - 1) check_val("last_addr", 32'(readaddress), BASE_I + (10 * WPE - 1) * 16);
            last_rd = cyc;
            rd_idx++;
            pend_t.push_back(cyc + RD_LAT);
            pend_a.push_back(int'(readaddress));
        end
        if (done) done_cnt++;
    end

    // Valid data only in the sample slot; random junk every other cycle.
    always @(posedge clk) begin
        #1;
        if (pend_t.size() > 0 && pend_t[0] == cyc) begin
            readdata = mem.exists(pend_a[0]) ? mem[pend_a[0]] : 16'h0;
            void'(pend_t.pop_front());
            void'(pend_a.pop_front());
        end else begin
            readdata = 16'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        int c;
        c = 0;
        while (done_cnt == 0 && c < budget) begin
            tick();
            start = poke && busy && ($urandom_range(0, 399) == 0);
            c++;
        end
        start = 1'b0;
    endtask

    task automatic score(output int errs, output int fa, output int fe, output int fg);
        errs = 0; fa = 0; fe = 0; fg = 0;
        for (int i = 0; i < NREAD; i++) begin
            if (int'(mem[exp_addr[i]]) != exp_data[i]) begin
                if (errs == 0) begin
                    fa = exp_addr[i];
                    fe = exp_data[i];
                    fg = int'(mem[exp_addr[i]]);
                end
                errs++;
            end
        end
    endtask

    int e_errs, e_fa, e_fe, e_fg, c, idx;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        readdata = '0;
        build_model();
        for (int i = 0; i < NREAD; i++) mem[exp_addr[i]] = 16'(exp_data[i]);
        repeat (3) tick();
        check_val("rst_read", read, 0);
        check_val("rst_addr", 32'(readaddress), 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pass", pass, 0);
        check_val("rst_errcnt", error_count, 0);
        check_val("rst_fe_addr", 32'(first_err_addr), 0);
        check_val("rst_fe_exp", first_err_exp, 0);
        check_val("rst_fe_got", first_err_got, 0);
        rst = 1'b0;
        tick();

        // clean image, junk readdata, stray starts while busy
        rd_idx = 0; done_cnt = 0;
        pulse_start();
        check_val("busy_after_start", busy, 1);
        wait_done(40000, 1'b1);
        tick();
        check_val("a_done_cnt", done_cnt, 1);
        check_val("a_reads", rd_idx, NREAD);
        check_val("a_pass", pass, 1);
        check_val("a_errcnt", error_count, 0);
        check_val("a_fe_addr", 32'(first_err_addr), 0);
        repeat (5) tick();
        check_val("a_hold_pass", pass, 1);
        check_val("a_hold_busy", busy, 0);
        check_val("a_hold_done", done_cnt, 1);

        // corrupted image: two fixed words plus a few random ones late in the pass
        mem[32] = 16'hFFFF;
        mem[48] = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            idx = $urandom_range(200, NREAD - 1);
            mem[exp_addr[idx]] = 16'(exp_data[idx]) ^ 16'($urandom_range(1, 65535));
        end
        score(e_errs, e_fa, e_fe, e_fg);

        rd_idx = 0; done_cnt = 0;
        pulse_start();
        c = 0;
        while (rd_idx < 100 && c < 2000) begin
            tick();
            c++;
        end
        check_val("reach_rd100", rd_idx >= 100, 1);
        check_val("b_mid_errcnt", error_count, 2);
        check_val("b_mid_fe_addr", 32'(first_err_addr), 32);
        rst = 1'b1;
        tick();
        check_val("abort_read", read, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_errcnt", error_count, 0);
        check_val("abort_pass", pass, 0);
        check_val("abort_fe_addr", 32'(first_err_addr), 0);
        check_val("abort_addr", 32'(readaddress), 0);
        rst = 1'b0;
        pend_t.delete();
        pend_a.delete();
        repeat (3) tick();
        check_val("abort_no_done", done_cnt, 0);

        rd_idx = 0; done_cnt = 0;
        pulse_start();
        wait_done(40000, 1'b0);
        tick();
        check_val("b_done_cnt", done_cnt, 1);
        check_val("b_reads", rd_idx, NREAD);
        check_val("b_errcnt", error_count, e_errs);
        check_val("b_fe_addr", 32'(first_err_addr), e_fa);
        check_val("b_fe_exp", first_err_exp, e_fe);
        check_val("b_fe_got", first_err_got, e_fg);
        check_val("b_fe_got_ffff", first_err_got, 32'hFFFF);
        check_val("b_pass", pass, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
